// File: rtl/toggle_line_rx.sv
// toggle_line_rx
// ---------------------------------------------------------------------------
// Receive-side decoder for the toggle-coded serial link. The far end drives
// the line from a T flip-flop: a data 1 toggles the line and a data 0 holds it.
// This block:
//   - recovers the bit stream from line transitions (NRZI decode),
//   - drops the zero stuffed after five consecutive ones,
//   - finds 0x7E flags and 7-ones aborts,
//   - assembles LSB-first bytes and frames them.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   en           bit strobe; the line is sampled only when en=1
//   line         toggle-coded line level
//   byte_out     last assembled byte; holds between updates
//   byte_valid   one-cycle pulse; byte_out is new
//   frame_start  one-cycle pulse with the first byte_valid of a frame
//   frame_end    one-cycle pulse on a correctly aligned closing flag
//   err          one-cycle pulse on abort, misaligned flag or overlength
//   busy         high while a frame is open (DATA state)
//   state_dbg    current FSM state (0=HUNT, 1=SYNC, 2=DATA)
//
// Handshake: byte_valid is a one-cycle, push-only strobe. There is no
// back-pressure; the consumer must take byte_out in the cycle byte_valid is
// high. Bytes already delivered are never retracted; an err pulse tells the
// consumer to discard the frame in progress.
// ---------------------------------------------------------------------------
module toggle_line_rx #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       line,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic       prev_q, prev_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] len_q, len_d;
    logic [7:0] shift_q, shift_d;

    logic [7:0] byte_out_d;
    logic       byte_valid_d;
    logic       frame_start_d;
    logic       frame_end_d;
    logic       err_d;
    logic       busy_d;

    // Per-bit classification of the decoded bit.
    logic       dbit;
    logic       is_abort;
    logic       is_flag;
    logic       is_stuff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            prev_q      <= 1'b0;
            ones_q      <= 3'd0;
            bit_cnt_q   <= 3'd0;
            len_q       <= 8'd0;
            shift_q     <= 8'd0;
            byte_out    <= 8'h00;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            byte_out    <= byte_out_d;
            byte_valid  <= byte_valid_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
            err         <= err_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        ones_d        = ones_q;
        bit_cnt_d     = bit_cnt_q;
        len_d         = len_q;
        shift_d       = shift_q;
        byte_out_d    = byte_out;
        byte_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        err_d         = 1'b0;
        dbit          = 1'b0;
        is_abort      = 1'b0;
        is_flag       = 1'b0;
        is_stuff      = 1'b0;

        if (en) begin
            dbit   = line ^ prev_q;
            prev_d = line;

            // The run length is judged before a 0 clears it.
            is_abort = dbit  && (ones_q == 3'd6);
            is_flag  = !dbit && (ones_q == 3'd6);
            is_stuff = !dbit && (ones_q == 3'd5);

            if (dbit)
                ones_d = (ones_q == 3'd7) ? 3'd7 : 3'(ones_q + 3'd1);
            else
                ones_d = 3'd0;

            // Flag and abort outrank a byte completing on the same bit.
            if (is_abort) begin
                if (state_q == DATA)
                    err_d = 1'b1;
                state_d   = HUNT;
                bit_cnt_d = 3'd0;
                len_d     = 8'd0;
            end else if (is_flag) begin
                if (state_q == DATA) begin
                    // Aligned closing flag: its leading 0 and six 1s took
                    // exactly bit positions 0..6 of a fresh byte.
                    if (bit_cnt_q == 3'd7)
                        frame_end_d = 1'b1;
                    else
                        err_d = 1'b1;
                end
                // Every flag (opening, repeated or closing) leaves us in SYNC
                // ready for the next frame.
                state_d   = SYNC;
                bit_cnt_d = 3'd0;
                len_d     = 8'd0;
            end else if (!is_stuff && (state_q != HUNT)) begin
                shift_d = {dbit, shift_q[7:1]};
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d = 3'd0;
                    if (state_q == SYNC) begin
                        state_d       = DATA;
                        byte_out_d    = shift_d;
                        byte_valid_d  = 1'b1;
                        frame_start_d = 1'b1;
                        len_d         = 8'd1;
                    end else if (len_q == MAX_LEN_L) begin
                        // This byte would exceed the frame limit: drop it.
                        err_d     = 1'b1;
                        state_d   = HUNT;
                        len_d     = 8'd0;
                    end else begin
                        byte_out_d   = shift_d;
                        byte_valid_d = 1'b1;
                        len_d        = 8'(len_q + 8'd1);
                    end
                end else begin
                    bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                end
            end
        end

        busy_d = (state_d == DATA);
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_toggle_line_rx.sv
// Directed bench for toggle_line_rx. Bits are toggle-encoded by the bench's
// own transmitter model (line flips for a 1), with zero stuffing applied to
// data bytes. Pulses are collected per section and checked against
// hand-computed values.
module tb_toggle_line_rx;

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       line;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       frame_end;
    logic       err;
    logic       busy;
    logic [1:0] state_dbg;

    toggle_line_rx #(.MAX_LEN(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .line        (line),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .err         (err),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // transmitter model and per-section pulse statistics
    logic       line_lvl  = 1'b0;
    int         tx_ones   = 0;
    bit         gap_mode  = 1'b0;
    int         bit_idx   = 0;
    int         bv_n      = 0;
    int         fs_n      = 0;
    int         fs_bv     = 0;
    int         fe_n      = 0;
    int         err_n     = 0;
    int         bv_at     = 0;
    int         fe_at     = 0;
    int         spurious  = 0;
    logic [7:0] last_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        bit_idx  = 0;
        bv_n     = 0;
        fs_n     = 0;
        fs_bv    = 0;
        fe_n     = 0;
        err_n    = 0;
        bv_at    = 0;
        fe_at    = 0;
        spurious = 0;
    endtask

    // One line bit. In gap mode the new level is presented during an en=0
    // cycle first, then held for the en=1 cycle that samples it.
    task automatic send_bit(input logic b);
        if (gap_mode) begin
            @(negedge clk);
            en = 1'b0;
            if (b) line_lvl = ~line_lvl;
            line = line_lvl;
            @(posedge clk);
            #1;
            if (byte_valid || frame_start || frame_end || err) spurious++;
            @(negedge clk);
            en = 1'b1;
        end else begin
            @(negedge clk);
            if (b) line_lvl = ~line_lvl;
            line = line_lvl;
            en   = 1'b1;
        end
        @(posedge clk);
        #1;
        bit_idx++;
        if (byte_valid) begin
            bv_n++;
            last_byte = byte_out;
            bv_at     = bit_idx;
            if (frame_start) fs_bv++;
        end
        if (frame_start) fs_n++;
        if (frame_end) begin
            fe_n++;
            fe_at = bit_idx;
        end
        if (err) err_n++;
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b);
        if (b) tx_ones++;
        else   tx_ones = 0;
        if (tx_ones == 5) begin
            send_bit(1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tx_ones = 0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        line = 1'b0;

        // ---- reset state (asynchronous, before any clock edge) ----
        #2 rst = 1'b0;
        #1;
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_pulses", 32'({byte_valid, frame_start, frame_end, err}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(S_HUNT));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ---- idle line ----
        clr_stats();
        for (int i = 0; i < 40; i++) send_bit(1'b0);
        check("idle_pulses", 32'(bv_n + fs_n + fe_n + err_n), 32'd0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_state", 32'(state_dbg), 32'(S_HUNT));

        // ---- basic frame: flag, A5, flag ----
        clr_stats();
        send_flag();
        send_byte(8'hA5);
        check("basic_busy_mid", 32'(busy), 32'h1);
        send_flag();
        check("basic_bv_n", 32'(bv_n), 32'd1);
        check("basic_byte", 32'(last_byte), 32'hA5);
        check("basic_fs_with_bv", 32'(fs_bv), 32'd1);
        check("basic_fe_n", 32'(fe_n), 32'd1);
        check("basic_fe_delay", 32'(fe_at - bv_at), 32'd8);
        check("basic_err_n", 32'(err_n), 32'd0);
        check("basic_busy_after", 32'(busy), 32'h0);
        check("basic_state", 32'(state_dbg), 32'(S_SYNC));

        // ---- stuffing: FF, en high ----
        clr_stats();
        send_flag();
        send_byte(8'hFF);
        send_flag();
        check("stuff_bv_n", 32'(bv_n), 32'd1);
        check("stuff_byte", 32'(last_byte), 32'hFF);
        check("stuff_fe_n", 32'(fe_n), 32'd1);
        check("stuff_err_n", 32'(err_n), 32'd0);
        check("stuff_bits", 32'(bit_idx), 32'd25);

        // ---- stuffing: FF, en toggling ----
        clr_stats();
        gap_mode = 1'b1;
        send_flag();
        send_byte(8'hFF);
        send_flag();
        gap_mode = 1'b0;
        check("gap_bv_n", 32'(bv_n), 32'd1);
        check("gap_byte", 32'(last_byte), 32'hFF);
        check("gap_fe_n", 32'(fe_n), 32'd1);
        check("gap_err_n", 32'(err_n), 32'd0);
        check("gap_spurious", 32'(spurious), 32'd0);

        // ---- abort after one data byte ----
        clr_stats();
        send_flag();
        send_byte(8'h11);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        tx_ones = 0;
        check("abort_bv_n", 32'(bv_n), 32'd1);
        check("abort_err_n", 32'(err_n), 32'd1);
        check("abort_fe_n", 32'(fe_n), 32'd0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_state", 32'(state_dbg), 32'(S_HUNT));
        clr_stats();
        send_flag();
        send_byte(8'h3C);
        send_flag();
        check("recover_bv_n", 32'(bv_n), 32'd1);
        check("recover_byte", 32'(last_byte), 32'h3C);
        check("recover_fe_n", 32'(fe_n), 32'd1);
        check("recover_err_n", 32'(err_n), 32'd0);

        // ---- misaligned flag after 3 data bits ----
        // Bits 0,1,0 plus the flag's 0 and first four 1s complete byte F2
        // before the flag is recognised with bit_cnt=2.
        clr_stats();
        send_flag();
        send_byte(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_flag();
        check("misal_err_n", 32'(err_n), 32'd1);
        check("misal_fe_n", 32'(fe_n), 32'd0);
        check("misal_bv_n", 32'(bv_n), 32'd2);
        check("misal_byte", 32'(last_byte), 32'hF2);
        check("misal_state", 32'(state_dbg), 32'(S_SYNC));
        check("misal_busy", 32'(busy), 32'h0);

        // ---- overlength: 17 bytes with MAX_LEN=16 ----
        clr_stats();
        send_flag();
        for (int i = 0; i < 17; i++) send_byte(8'(i));
        send_flag();
        check("len_bv_n", 32'(bv_n), 32'd16);
        check("len_last_byte", 32'(last_byte), 32'h0F);
        check("len_err_n", 32'(err_n), 32'd1);
        check("len_fe_n", 32'(fe_n), 32'd0);
        check("len_fs_n", 32'(fs_n), 32'd1);
        check("len_busy", 32'(busy), 32'h0);

        // ---- reset mid-frame ----
        clr_stats();
        send_flag();
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_byte_out", 32'(byte_out), 32'h0F);
        @(negedge clk);
        rst      = 1'b0;
        en       = 1'b0;
        line_lvl = 1'b0;
        line     = 1'b0;
        tx_ones  = 0;
        #1;
        check("midrst_byte_out", 32'(byte_out), 32'h00);
        check("midrst_pulses", 32'({byte_valid, frame_start, frame_end, err, busy}), 32'h0);
        check("midrst_state", 32'(state_dbg), 32'(S_HUNT));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clr_stats();
        send_flag();
        send_byte(8'h5A);
        send_flag();
        check("post_rst_bv_n", 32'(bv_n), 32'd1);
        check("post_rst_byte", 32'(last_byte), 32'h5A);
        check("post_rst_fs_n", 32'(fs_n), 32'd1);
        check("post_rst_fe_n", 32'(fe_n), 32'd1);
        check("post_rst_err_n", 32'(err_n), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
